// File: rtl/cy_rx.sv
// UART receiver, 8N1 (1 or 2 stop bits accepted), bit period CLKDIV+1 clocks.
// Valid pulse 4136 clocks after the rx falling edge at defaults; no backpressure.
module cy_rx #(
  parameter int CLKDIV = 434,
  parameter int HALF   = CLKDIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [9:0] CLKDIV_C = 10'(CLKDIV);
  localparam logic [9:0] HALF_C   = 10'(HALF);

  typedef enum logic [2:0] {
    S_Idle     = 3'd0,
    S_Start    = 3'd1,
    S_Data     = 3'd2,
    S_Stop     = 3'd3,
    S_WaitHigh = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_Idle;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_Idle: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = S_Start;
        end
      end
      S_Start: begin
        if (cnt_q == HALF_C) begin
          if (!rx_s) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_Data;
          end else begin
            state_d = S_Idle;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_Data: begin
        if (cnt_q == CLKDIV_C) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd7) state_d = S_Stop;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_Stop: begin
        if (cnt_q == CLKDIV_C) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_Idle;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WaitHigh;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      // A break or stuck-low line parks here instead of framing zero bytes.
      S_WaitHigh: begin
        if (rx_s) state_d = S_Idle;
      end
      default: state_d = S_Idle;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q == S_Start) || (state_q == S_Data) || (state_q == S_Stop);

endmodule
